regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the 32x32 MIPS register file. It shares the register file's single write port between two sources:
- the in-order pipeline writeback (source A, including JAL link writes), which cannot be stalled;
- a long-latency unit (source B, e.g. multi-cycle load/multiply), which uses a valid/ready handshake.

It also tracks which registers have an outstanding source-B result, for hazard detection in decode.

---
 rtl/regfile_wb_arbiter_if.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of request, handshake, scoreboard and write-port signals shared
// between the register-file write arbiter and its clients.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32
);
  // Source A: in-order pipeline writeback (never stalled)
  logic              a_valid;
  logic [4:0]        a_addr;
  logic              a_link;
  logic [DATA_W-1:0] a_data;
  // Source B: long-latency unit, valid/ready handshake
  logic              b_valid;
  logic              b_ready;
  logic [4:0]        b_addr;
  logic [DATA_W-1:0] b_data;
  // Scoreboard allocation from issue, busy flags back to decode
  logic              alloc_valid;
  logic [4:0]        alloc_addr;
  logic [31:0]       busy;
  logic              hold_valid;
  // Register file write port
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output a_valid, a_addr, a_link, a_data,
    output b_valid, b_addr, b_data,
    output alloc_valid, alloc_addr,
    input  b_ready, busy, hold_valid,
    input  wb_we, wb_addr, wb_data
  );

  modport slave (
    input  a_valid, a_addr, a_link, a_data,
    input  b_valid, b_addr, b_data,
    input  alloc_valid, alloc_addr,
    output b_ready, busy, hold_valid,
    output wb_we, wb_addr, wb_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 MIPS register file. Shares the single
// write port between the unstallable pipeline writeback (A) and a
// long-latency unit (B), parks at most one A write, prevents B starvation,
// and keeps a per-register busy scoreboard of outstanding B results.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_HOLD,
    SRC_B,
    SRC_A
  } src_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic              hold_valid_q;
  logic [4:0]        hold_addr_q;
  logic [DATA_W-1:0] hold_data_q;
  logic [3:0]        starve_q;
  logic [31:1]       busy_q;
  logic              wb_we_q;
  logic [4:0]        wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;

  src_e              winner;
  logic [4:0]        a_eff_addr;
  logic [4:0]        win_addr;
  logic [DATA_W-1:0] win_data;
  logic              b_xfer;
  logic              a_park;
  logic [31:0]       busy_set;
  logic [31:0]       busy_clr;

  assign a_eff_addr = bus.a_link ? 5'd31 : bus.a_addr;

  // Pick this cycle's winner by fixed priority: parked A, starved B, A, B.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    winner   = SRC_NONE;
    win_addr = a_eff_addr;
    win_data = bus.a_data;
    if (rst) begin
      winner = SRC_NONE;
    end else if (hold_valid_q) begin
      winner   = SRC_HOLD;
      win_addr = hold_addr_q;
      win_data = hold_data_q;
    end else if (bus.b_valid && (starve_q == LIMIT)) begin
      winner   = SRC_B;
      win_addr = bus.b_addr;
      win_data = bus.b_data;
    end else if (bus.a_valid) begin
      winner = SRC_A;
    end else if (bus.b_valid) begin
      winner   = SRC_B;
      win_addr = bus.b_addr;
      win_data = bus.b_data;
    end
  end

  assign bus.b_ready = (winner == SRC_B);
  assign b_xfer      = bus.b_valid && bus.b_ready;
  // A that loses arbitration must park; only hold or a starved B can beat it.
  assign a_park      = bus.a_valid && (winner != SRC_A) && !rst;

  // Scoreboard set/clear masks; bit 0 is dropped when the flags are stored.
  assign busy_set = bus.alloc_valid ? (32'd1 << bus.alloc_addr) : 32'd0;
  assign busy_clr = b_xfer          ? (32'd1 << bus.b_addr)     : 32'd0;

  // Control state: write port, hold flag, starve counter and busy flags.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_q      <= 1'b0;
      wb_addr_q    <= 5'd0;
      wb_data_q    <= '0;
      hold_valid_q <= 1'b0;
      starve_q     <= 4'd0;
      busy_q       <= '0;
    end else begin
      // A winner aimed at r0 uses the slot but writes nothing.
      if ((winner != SRC_NONE) && (win_addr != 5'd0)) begin
        wb_we_q   <= 1'b1;
        wb_addr_q <= win_addr;
        wb_data_q <= win_data;
      end else begin
        wb_we_q <= 1'b0;
      end

      if (a_park) begin
        hold_valid_q <= 1'b1;
      end else if (winner == SRC_HOLD) begin
        hold_valid_q <= 1'b0;
      end

      if (b_xfer || !bus.b_valid) begin
        starve_q <= 4'd0;
      end else if (starve_q != LIMIT) begin
        starve_q <= starve_q + 4'd1;
      end

      // Set after clear so a same-address alloc wins over a B transfer.
      busy_q <= (busy_q & ~busy_clr[31:1]) | busy_set[31:1];
    end
  end

  // Parked A payload; meaningful only while hold_valid_q is set.
  // NOTE: payload registers are left unreset; the valid flag alone guards them.
  always_ff @(posedge clk) begin
    if (a_park) begin
      hold_addr_q <= a_eff_addr;
      hold_data_q <= bus.a_data;
    end
  end

  assign bus.busy       = {busy_q, 1'b0};
  assign bus.hold_valid = hold_valid_q;
  assign bus.wb_we      = wb_we_q;
  assign bus.wb_addr    = wb_addr_q;
  assign bus.wb_data    = wb_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic clk;
  logic rst;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W)) bus ();

  regfile_wb_arbiter #(
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         pending_a[$];   // A writes that lost arbitration, oldest first
  int          b_waited;       // cycles B has been refused in a row
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_ad_known;     // wb_addr/wb_data predictable (not after an r0 drop)

  task automatic step(input logic r,
                      input logic av, input logic [4:0] aa, input logic al, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic cv, input logic [4:0] ca);
    int   who;  // 0 none, 1 parked A, 2 B, 3 A
    wr_t  a_wr;
    wr_t  w;
    logic exp_ready;
    @(negedge clk);
    rst             = r;
    bus.a_valid     = av;
    bus.a_addr      = aa;
    bus.a_link      = al;
    bus.a_data      = ad;
    bus.b_valid     = bv;
    bus.b_addr      = ba;
    bus.b_data      = bd;
    bus.alloc_valid = cv;
    bus.alloc_addr  = ca;
    #1;
    a_wr.addr = al ? 5'd31 : aa;
    a_wr.data = ad;
    who = 0;
    if (!r) begin
      if (pending_a.size() > 0)               who = 1;
      else if (bv && b_waited >= STARVE_LIMIT) who = 2;
      else if (av)                             who = 3;
      else if (bv)                             who = 2;
    end
    exp_ready = (who == 2);
    check("b_ready", bus.b_ready, exp_ready);

    if (r) begin
      pending_a.delete();
      b_waited   = 0;
      m_busy     = '0;
      m_we       = 1'b0;
      m_addr     = '0;
      m_data     = '0;
      m_ad_known = 1'b1;
    end else begin
      w.addr = '0;
      w.data = '0;
      if (who == 1) w = pending_a.pop_front();
      else if (who == 2) begin w.addr = ba; w.data = bd; end
      else if (who == 3) w = a_wr;
      if (who == 0) m_we = 1'b0;
      else if (w.addr == 5'd0) begin
        m_we       = 1'b0;
        m_ad_known = 1'b0;
      end else begin
        m_we       = 1'b1;
        m_addr     = w.addr;
        m_data     = w.data;
        m_ad_known = 1'b1;
      end
      if (av && who != 3) pending_a.push_back(a_wr);
      if (!bv || who == 2) b_waited = 0;
      else if (b_waited < STARVE_LIMIT) b_waited++;
      if (who == 2) m_busy[ba] = 1'b0;
      if (cv && ca != 5'd0) m_busy[ca] = 1'b1;
    end

    @(posedge clk);
    #1;
    check("wb_we", bus.wb_we, m_we);
    if (m_ad_known) begin
      check("wb_addr", bus.wb_addr, m_addr);
      check("wb_data", bus.wb_data, m_data);
    end
    check("busy", bus.busy, m_busy);
    check("hold_valid", bus.hold_valid, pending_a.size() != 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.a_valid     = 0;
    bus.a_addr      = 0;
    bus.a_link      = 0;
    bus.a_data      = 0;
    bus.b_valid     = 0;
    bus.b_addr      = 0;
    bus.b_data      = 0;
    bus.alloc_valid = 0;
    bus.alloc_addr  = 0;
    b_waited   = 0;
    m_busy     = '0;
    m_we       = 0;
    m_addr     = 0;
    m_data     = 0;
    m_ad_known = 1;

    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 0, 32'hdead, 1, 3, 32'h1, 1, 9);
    check("rst_wb_data", bus.wb_data, 32'h0);
    check("rst_busy", bus.busy, 32'h0);

    // A beats a non-starved B
    step(0, 1, 5, 0, 32'h1234, 1, 3, 32'h77, 0, 0);
    check("a_first_addr", bus.wb_addr, 5);
    check("a_first_data", bus.wb_data, 32'h1234);
    idle();
    check("idle_hold_addr", bus.wb_addr, 5);

    // JAL link and r0 drop
    step(0, 1, 7, 1, 32'h400, 0, 0, 0, 0, 0);
    check("link_addr", bus.wb_addr, 31);
    step(0, 1, 0, 0, 32'h999, 0, 0, 0, 0, 0);
    check("r0_we", bus.wb_we, 0);

    // Starvation: A every cycle, B to r9 held until accepted in 5th cycle
    for (int i = 0; i < 5; i++)
      step(0, 1, 5'(10 + i), 0, 32'h100 + i, 1, 9, 32'hbeef, 0, 0);
    check("starve_b_addr", bus.wb_addr, 9);
    check("starve_parked", bus.hold_valid, 1);
    for (int i = 5; i < 8; i++)
      step(0, 1, 5'(10 + i), 0, 32'h100 + i, 0, 0, 0, 0, 0);
    idle();
    check("starve_last_a", bus.wb_data, 32'h107);
    idle();

    // Scoreboard
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    check("alloc9", bus.busy[9], 1);
    step(0, 0, 0, 0, 0, 1, 9, 32'h9, 0, 0);
    check("xfer9_clear", bus.busy[9], 0);
    step(0, 0, 0, 0, 0, 1, 9, 32'h9, 1, 9);
    check("alloc_wins", bus.busy[9], 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("alloc0", bus.busy[0], 0);
    step(0, 0, 0, 0, 0, 1, 9, 32'h9, 0, 0);

    // B alone is accepted immediately
    step(0, 0, 0, 0, 0, 1, 3, 32'h55, 0, 0);
    check("b_only_addr", bus.wb_addr, 3);
    check("b_only_data", bus.wb_data, 32'h55);
    idle();
    check("no_req_we", bus.wb_we, 0);

    // Reset while a write is parked and r9 is busy
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    for (int i = 0; i < 5; i++)
      step(0, 1, 5'(20 + i), 0, 32'h200 + i, 1, 4, 32'h44, 0, 0);
    check("pre_rst_hold", bus.hold_valid, 1);
    check("pre_rst_busy", bus.busy, 32'h200);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_hold", bus.hold_valid, 0);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_we", bus.wb_we, 0);
    idle();
    check("parked_dropped", bus.wb_we, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic       r, av, al, bv, cv;
      logic [4:0] aa, ba, ca;
      r  = ($urandom_range(0, 199) == 0);
      av = ($urandom_range(0, 99) < 55);
      al = ($urandom_range(0, 9) == 0);
      bv = ($urandom_range(0, 99) < 45);
      cv = ($urandom_range(0, 99) < 20);
      aa = 5'($urandom_range(0, 31));
      ba = 5'($urandom_range(0, 31));
      ca = 5'($urandom_range(0, 31));
      step(r, av, aa, al, $urandom(), bv, ba, $urandom(), cv, ca);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
